// File: rtl/cellrv32_cpu_cp_sequencer.sv
// Co-processor dispatch sequencer: one-cycle start to a selected slot, wait for
// its valid, forward the result one cycle later; abort on trap, error on timeout.
module cellrv32_cpu_cp_sequencer #(
   parameter int XLEN    = 32,
   parameter int NUM_CP  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   trap_i,
   input  logic [NUM_CP-1:0]      req_i,
   output logic                   busy_o,
   output logic [NUM_CP-1:0]      cp_start_o,
   input  logic [NUM_CP-1:0]      cp_valid_i,
   input  logic [NUM_CP*XLEN-1:0] cp_res_i,
   output logic [XLEN-1:0]        res_o,
   output logic                   valid_o,
   output logic                   err_o
);

   localparam int SW = (NUM_CP > 1) ? $clog2(NUM_CP) : 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_DONE, S_ERROR} state_t;

   state_t                       state, state_nxt;
   logic [SW-1:0]                sel, sel_nxt, req_idx;
   logic [7:0]                   cnt, cnt_nxt;
   logic                         req_onehot;
   logic [NUM_CP-1:0][XLEN-1:0]  res_arr;

   assign res_arr    = cp_res_i;
   assign req_onehot = $onehot(req_i);

   always_comb begin
      req_idx = '0;
      for (int i = 0; i < NUM_CP; i++)
         if (req_i[i]) req_idx = SW'(i);
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state <= S_IDLE;
         sel   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      cnt_nxt   = cnt;
      unique case (state)
         S_IDLE: begin
            if (req_i != '0) begin
               if (req_onehot && !trap_i) begin
                  sel_nxt   = req_idx;
                  cnt_nxt   = '0;
                  state_nxt = S_START;
               end else if (!req_onehot) begin
                  state_nxt = S_ERROR;
               end
            end
         end
         S_START: begin
            if (trap_i)               state_nxt = S_IDLE;
            else if (cp_valid_i[sel]) state_nxt = S_DONE;
            else                      state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // saturate so the counter can never wrap back under the limit
            cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
            if (trap_i)                         state_nxt = S_IDLE;
            else if (cp_valid_i[sel])           state_nxt = S_DONE;
            else if (cnt == 8'(TIMEOUT - 1))    state_nxt = S_ERROR;
         end
         S_DONE:  state_nxt = S_IDLE;
         S_ERROR: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // per-slot start decode: only the latched slot, only in START
   for (genvar k = 0; k < NUM_CP; k++) begin : g_start
      assign cp_start_o[k] = (state == S_START) && (sel == SW'(k));
   end

   assign busy_o  = (state != S_IDLE);
   assign valid_o = (state == S_DONE) || (state == S_ERROR);
   assign err_o   = (state == S_ERROR);
   assign res_o   = (state == S_DONE) ? res_arr[sel] : '0;

endmodule

// File: tb/tb_cellrv32_cpu_cp_sequencer.sv
// Bench for cellrv32_cpu_cp_sequencer: directed vector table, hand-written multi-cycle
// sequences, and random traffic against a transaction-level reference model.
module tb_cellrv32_cpu_cp_sequencer;

   localparam int XLEN = 32;
   localparam int NCP  = 8;

   logic                 clk = 1'b0;
   logic                 rstn, trap;
   logic [NCP-1:0]       req, cpv;
   logic [NCP*XLEN-1:0]  cres;
   logic                 busy [2];
   logic [NCP-1:0]       start [2];
   logic [XLEN-1:0]      res [2];
   logic                 vld [2];
   logic                 err [2];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // dut 0: default timeout, dut 1: short timeout
   cellrv32_cpu_cp_sequencer #(.XLEN(XLEN), .NUM_CP(NCP), .TIMEOUT(255)) dut0 (
      .clk_i(clk), .rstn_i(rstn), .trap_i(trap), .req_i(req), .busy_o(busy[0]),
      .cp_start_o(start[0]), .cp_valid_i(cpv), .cp_res_i(cres), .res_o(res[0]),
      .valid_o(vld[0]), .err_o(err[0]));

   cellrv32_cpu_cp_sequencer #(.XLEN(XLEN), .NUM_CP(NCP), .TIMEOUT(16)) dut1 (
      .clk_i(clk), .rstn_i(rstn), .trap_i(trap), .req_i(req), .busy_o(busy[1]),
      .cp_start_o(start[1]), .cp_valid_i(cpv), .cp_res_i(cres), .res_o(res[1]),
      .valid_o(vld[1]), .err_o(err[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic chk_dut(input int d, input string tag, input logic b, input logic [7:0] s,
                          input logic v, input logic e, input logic [31:0] r);
      chk($sformatf("%s.d%0d.busy", tag, d),  32'(busy[d]),  32'(b));
      chk($sformatf("%s.d%0d.start", tag, d), 32'(start[d]), 32'(s));
      chk($sformatf("%s.d%0d.valid", tag, d), 32'(vld[d]),   32'(v));
      chk($sformatf("%s.d%0d.err", tag, d),   32'(err[d]),   32'(e));
      chk($sformatf("%s.d%0d.res", tag, d),   res[d],        r);
   endtask

   // drive one cycle's inputs after the falling edge; slot k result = base + k
   task automatic cyc_in(input logic rn, input logic [7:0] rq, input logic tp,
                         input logic [7:0] cv, input logic [31:0] base);
      @(negedge clk);
      rstn = rn; req = rq; trap = tp; cpv = cv;
      for (int k = 0; k < NCP; k++) cres[k*XLEN +: XLEN] = base + 32'(k);
      #1;
   endtask

   task automatic do_reset();
      cyc_in(1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
      cyc_in(1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
      cyc_in(1'b1, 8'h00, 1'b0, 8'h00, 32'h0);
   endtask

   typedef struct {
      logic        rstn;
      logic [7:0]  req;
      logic        trap;
      logic [7:0]  cv;
      logic [31:0] base;
      logic        busy;
      logic [7:0]  start;
      logic        valid;
      logic        err;
      logic [31:0] res;
   } vec_t;

   vec_t tbl [19];

   // reference model: op age since start (-1 = no op in flight) and pending strobe
   int          m_age [2];
   int          m_sel [2];
   int          m_strobe [2];   // 0 none, 1 result, 2 error
   int          m_tmo [2] = '{255, 16};

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin m_age[d] = -1; m_strobe[d] = 0; m_sel[d] = 0; end
   endtask

   task automatic model_check(input int d, input string tag);
      logic [31:0] er;
      er = (m_strobe[d] == 1) ? cres[m_sel[d]*XLEN +: XLEN] : 32'h0;
      chk_dut(d, tag, (m_age[d] >= 0) || (m_strobe[d] != 0),
              (m_age[d] == 0) ? 8'(1 << m_sel[d]) : 8'h00,
              m_strobe[d] != 0, m_strobe[d] == 2, er);
   endtask

   task automatic model_step(input int d);
      int n;
      n = $countones(req);
      if (!rstn) begin
         m_age[d] = -1; m_strobe[d] = 0;
      end else if (m_strobe[d] != 0) begin
         m_strobe[d] = 0;
      end else if (m_age[d] >= 0) begin
         if (trap) m_age[d] = -1;
         else if (cpv[m_sel[d]]) begin m_strobe[d] = 1; m_age[d] = -1; end
         else if (m_age[d] == m_tmo[d]) begin m_strobe[d] = 2; m_age[d] = -1; end
         else m_age[d]++;
      end else if (n == 1 && !trap) begin
         for (int k = 0; k < NCP; k++) if (req[k]) m_sel[d] = k;
         m_age[d] = 0;
      end else if (n > 1) begin
         m_strobe[d] = 2;
      end
   endtask

   initial begin
      rstn = 1'b0; req = '0; trap = 1'b0; cpv = '0; cres = '0;
      //           rstn req   trap cv    base          busy start v  e  res
      tbl[0]  = '{1'b1, 8'h00, 1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 8'h01, 1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
      tbl[2]  = '{1'b1, 8'h00, 1'b0, 8'h01, 32'h0,        1'b1, 8'h01, 1'b0, 1'b0, 32'h0};
      tbl[3]  = '{1'b1, 8'h00, 1'b0, 8'h00, 32'hF0000000, 1'b1, 8'h00, 1'b1, 1'b0, 32'hF0000000};
      tbl[4]  = '{1'b1, 8'h00, 1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
      tbl[5]  = '{1'b1, 8'h05, 1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
      tbl[6]  = '{1'b1, 8'h00, 1'b0, 8'h00, 32'h0,        1'b1, 8'h00, 1'b1, 1'b1, 32'h0};
      tbl[7]  = '{1'b1, 8'h00, 1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
      tbl[8]  = '{1'b1, 8'h02, 1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
      tbl[9]  = '{1'b1, 8'h04, 1'b0, 8'h00, 32'h0,        1'b1, 8'h02, 1'b0, 1'b0, 32'h0};
      tbl[10] = '{1'b1, 8'h04, 1'b0, 8'h04, 32'h0,        1'b1, 8'h00, 1'b0, 1'b0, 32'h0};
      tbl[11] = '{1'b1, 8'h00, 1'b0, 8'h04, 32'h0,        1'b1, 8'h00, 1'b0, 1'b0, 32'h0};
      tbl[12] = '{1'b1, 8'h00, 1'b0, 8'h02, 32'h0,        1'b1, 8'h00, 1'b0, 1'b0, 32'h0};
      tbl[13] = '{1'b1, 8'h00, 1'b0, 8'h00, 32'hABCD0,    1'b1, 8'h00, 1'b1, 1'b0, 32'hABCD1};
      tbl[14] = '{1'b1, 8'h08, 1'b1, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
      tbl[15] = '{1'b1, 8'h00, 1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
      tbl[16] = '{1'b1, 8'h08, 1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'h0};
      tbl[17] = '{1'b1, 8'h00, 1'b1, 8'h00, 32'h0,        1'b1, 8'h08, 1'b0, 1'b0, 32'h0};
      tbl[18] = '{1'b1, 8'h00, 1'b0, 8'h00, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'h0};

      do_reset();
      for (int i = 0; i < 19; i++) begin
         cyc_in(tbl[i].rstn, tbl[i].req, tbl[i].trap, tbl[i].cv, tbl[i].base);
         chk_dut(0, $sformatf("tbl%0d", i), tbl[i].busy, tbl[i].start, tbl[i].valid,
                 tbl[i].err, tbl[i].res);
      end

      // serial unit: valid 31 cycles after start -> result at T+33
      do_reset();
      cyc_in(1'b1, 8'h01, 1'b0, 8'h00, 32'h1);
      for (int c = 1; c <= 34; c++) begin
         cyc_in(1'b1, 8'h00, 1'b0, (c == 32) ? 8'h01 : 8'h00, 32'h1);
         chk_dut(0, $sformatf("serial%0d", c), c <= 33, (c == 1) ? 8'h01 : 8'h00,
                 c == 33, 1'b0, (c == 33) ? 32'h1 : 32'h0);
      end

      // trap in WAIT, then a fresh request is accepted
      do_reset();
      cyc_in(1'b1, 8'h02, 1'b0, 8'h00, 32'h0);
      for (int c = 1; c <= 6; c++) begin
         cyc_in(1'b1, 8'h00, c == 5, 8'h00, 32'h0);
         chk_dut(0, $sformatf("trap%0d", c), c <= 5, (c == 1) ? 8'h02 : 8'h00,
                 1'b0, 1'b0, 32'h0);
      end
      cyc_in(1'b1, 8'h02, 1'b0, 8'h00, 32'h0);
      chk_dut(0, "trap_req", 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      cyc_in(1'b1, 8'h00, 1'b0, 8'h00, 32'h0);
      chk_dut(0, "trap_restart", 1'b1, 8'h02, 1'b0, 1'b0, 32'h0);

      // timeout on the short-timeout instance: error strobe at T+18
      do_reset();
      cyc_in(1'b1, 8'h08, 1'b0, 8'h00, 32'h55);
      for (int c = 1; c <= 19; c++) begin
         cyc_in(1'b1, 8'h00, 1'b0, 8'h00, 32'h55);
         chk_dut(1, $sformatf("tmo%0d", c), c <= 18, (c == 1) ? 8'h08 : 8'h00,
                 c == 18, c == 18, 32'h0);
         if (c == 18) chk("tmo_long.err", 32'(err[0]), 32'h0);
      end

      // reset mid-operation: nothing follows it
      do_reset();
      cyc_in(1'b1, 8'h01, 1'b0, 8'h00, 32'h0);
      for (int c = 1; c <= 8; c++) begin
         cyc_in(c != 4, 8'h00, 1'b0, (c == 6) ? 8'h01 : 8'h00, 32'h0);
         if (c >= 5)
            for (int d = 0; d < 2; d++)
               chk_dut(d, $sformatf("rstmid%0d", c), 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
      end

      // random traffic against the reference model
      do_reset();
      model_reset();
      for (int n = 0; n < 2500; n++) begin
         logic [7:0] rq;
         logic [7:0] cv;
         rq = 8'h00;
         if ($urandom_range(0, 3) == 0)
            rq = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
         for (int k = 0; k < NCP; k++) cv[k] = ($urandom_range(0, 9) == 0);
         cyc_in($urandom_range(0, 299) != 0, rq, $urandom_range(0, 39) == 0, cv, $urandom);
         for (int d = 0; d < 2; d++) model_check(d, $sformatf("rnd%0d", n));
         @(posedge clk);
         for (int d = 0; d < 2; d++) model_step(d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
